demux_arbiter: RTL and testbench
================================

# demux_arbiter

Round-robin arbiter sitting upstream of the decryption demux, sharing its single 32-bit input port among three message sources. It accepts one 4-character word at a time from a requesting source. It drives the word with the matching decryptor `select` code and holds that code stable for a full serialization slot, so the demux never switches decryptors mid-word.

## Interface
- `MST_DWIDTH`, 32, width of a message word (4 characters).
- `SLOT_CYCLES`, 4, cycles per serialization slot; legal range 2..15.
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req0_i` / `req1_i` / `req2_i`  in  1 each  request from source 0 (Caesar), 1 (Scytale), 2 (ZigZag).
- `data0_i` / `data1_i` / `data2_i`  in  MST_DWIDTH each  word offered by each source.
- `gnt0_o` / `gnt1_o` / `gnt2_o`  out  1 each  one-cycle accept pulse per source.
- `data_o`  out  MST_DWIDTH  word to demux `data_i`.
- `valid_o`  out  1  to demux `valid_i`.
- `select_o`  out  2  to demux `select`; 2'b11 = no decryptor.
- `busy_o`  out  1  high whenever state is not IDLE.

## Operation
- Source handshake:
  - A source raises `reqN_i` with `dataN_i` stable and keeps both unchanged until it sees `gntN_o` high.
  - The word is consumed in the `gntN_o` cycle.
  - `reqN_i` dropping before grant is a protocol violation; the bench flags it, and the arbiter behaviour is then undefined.
- States:
  - IDLE: `select_o`=2'b11. Arbitrates every cycle.
  - SEND: exactly 1 cycle. Asserts `valid_o`, `data_o`=captured word, `select_o`=granted index, and that source's `gnt` pulse.
  - HOLD: SLOT_CYCLES-1 cycles. `valid_o`=0, `data_o`=0, `select_o` held. Arbitrates only on its last cycle.
  - TAIL: up to SLOT_CYCLES cycles. `select_o` still held while the demux drains; `valid_o`=0. Arbitrates every cycle.
- Transitions:
  - IDLE→SEND when any request is present.
  - SEND→HOLD.
  - HOLD→SEND on its last cycle if any request is present, otherwise →TAIL.
  - TAIL→SEND on any request; →IDLE after SLOT_CYCLES cycles with no request.
- Round-robin arbitration:
  - `last` pointer holds the most recently granted index; search order is last+1, last+2, last (mod 3).
  - `last` resets to 2, so source 0 has first priority.
  - `last` updates only when a grant is issued.
- Slot counter: 4-bit, loaded with SLOT_CYCLES-2 on entering HOLD and SLOT_CYCLES-1 on entering TAIL, decrements to 0. No wrap is possible.
- Simultaneous events: all three requesting at one arbitration point yields exactly one grant. Other requests stay pending; none are lost.
- Reset mid-operation: immediate return to IDLE. Any word already in SEND/HOLD is abandoned, and no grant is issued for a word that was not yet sent.

## Timing
- Reset values:
  - `data_o`=0, `valid_o`=0, `select_o`=2'b11, `busy_o`=0, all `gntN_o`=0.
  - state=IDLE, `last`=2, counter=0.
- All outputs are registered.
- Latency from IDLE: request sampled at edge k → SEND outputs visible after edge k.
- Throughput: back-to-back grants every SLOT_CYCLES cycles when requests are continuous. `valid_o` never asserts on consecutive cycles.
- `gntN_o` coincides with `valid_o` and is one-hot or all zero.
- `select_o` changes only on entering SEND or IDLE.

## Configuration
- `DEMUX_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, 0 > 1 > 2. The `last` pointer is not implemented.
  - Undefined (default): round-robin as above.
- All other behaviour and timing are identical in both builds.

## Test plan
- Reset values: assert `rst` asynchronously between edges → all outputs at reset values immediately, with `select_o`=2'b11.
- Single word: `req1_i`=1, `data1_i`=32'h44434241 in IDLE → next cycle `valid_o`=1, `data_o`=32'h44434241, `select_o`=2'b01, `gnt1_o`=1. Then `select_o` holds 01 for 2×SLOT_CYCLES-1 more cycles, then returns to 11 with `busy_o`=0.
- Contention (round-robin build): all three requesting continuously, 6 words each → grant order 0,1,2,0,1,2…, with `valid_o` pulses exactly 4 cycles apart. Each source receives 6 grants.
- Contention (`DEMUX_ARB_FIXED_PRIO_EN` build): same stimulus → all 6 source-0 words first, then source 1, then source 2.
- Request during TAIL: `req2_i` raised 2 cycles into TAIL → SEND on the next cycle with `select_o`=2'b10; no IDLE visit, so `busy_o` stays 1.
- Reset in HOLD: `rst` pulse 1 cycle after a grant to source 0, while `req1_i` is pending → after release, `last`=2 so source 0 wins if it re-requests at the same time as source 1. Source 1 is then granted next, with no lost or duplicate grants.

Source files
------------

// File: rtl/demux_arbiter.sv
// demux_arbiter
// Shares the decryption demux's single input port among three message
// sources (0 = Caesar, 1 = Scytale, 2 = ZigZag). One 4-character word is
// accepted per grant. Its decryptor select code is held for a whole
// serialization slot, so the demux never switches decryptors mid-word.
//
// Build option:
//   DEMUX_ARB_FIXED_PRIO_EN  defined   -> fixed priority 0 > 1 > 2
//                            undefined -> round-robin (default)

module demux_arbiter #(
    parameter int MST_DWIDTH  = 32,
    parameter int SLOT_CYCLES = 4     // legal range 2..15
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic                  req2_i,
    input  logic [MST_DWIDTH-1:0] data0_i,
    input  logic [MST_DWIDTH-1:0] data1_i,
    input  logic [MST_DWIDTH-1:0] data2_i,
    output logic                  gnt0_o,
    output logic                  gnt1_o,
    output logic                  gnt2_o,
    output logic [MST_DWIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic [1:0]            select_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2,
        ST_TAIL = 2'd3
    } state_e;

    // 2'b11 tells the demux that no decryptor is selected.
    localparam logic [1:0] SEL_NONE  = 2'b11;
    // HOLD lasts SLOT_CYCLES-1 cycles, TAIL up to SLOT_CYCLES cycles;
    // both count down to zero.
    localparam logic [3:0] HOLD_LOAD = 4'(SLOT_CYCLES - 2);
    localparam logic [3:0] TAIL_LOAD = 4'(SLOT_CYCLES - 1);

    state_e                state_q,  state_d;
    logic [3:0]            cnt_q,    cnt_d;
    logic [MST_DWIDTH-1:0] data_q,   data_d;
    logic                  valid_q,  valid_d;
    logic [1:0]            select_q, select_d;
    logic [2:0]            gnt_q,    gnt_d;
    logic                  busy_q,   busy_d;

    logic [2:0]            req_vec;
    logic                  pick_valid;
    logic [1:0]            pick_idx;
    logic [MST_DWIDTH-1:0] pick_data;
    logic                  arb_en;
    logic                  grant_go;

    assign req_vec = {req2_i, req1_i, req0_i};

`ifdef DEMUX_ARB_FIXED_PRIO_EN

    // Fixed priority: the lowest requesting index wins.
    always_comb begin
        pick_valid = |req_vec;
        pick_idx   = 2'd0;
        if (req_vec[0]) begin
            pick_idx = 2'd0;
        end else if (req_vec[1]) begin
            pick_idx = 2'd1;
        end else if (req_vec[2]) begin
            pick_idx = 2'd2;
        end
    end

`else

    // Index of the most recently granted source; 2 after reset so that
    // source 0 is searched first.
    logic [1:0] last_q, last_d;
    logic [1:0] cand1, cand2;

    // Next index in the circular order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : 2'(idx + 2'd1);
    endfunction

    assign cand1 = rr_next(last_q);
    assign cand2 = rr_next(cand1);

    // Round-robin search: last+1, then last+2, then last itself.
    always_comb begin
        pick_valid = |req_vec;
        pick_idx   = last_q;
        if (req_vec[cand1]) begin
            pick_idx = cand1;
        end else if (req_vec[cand2]) begin
            pick_idx = cand2;
        end
    end

    // The pointer only moves when a grant is actually issued.
    assign last_d = grant_go ? pick_idx : last_q;

    // Round-robin pointer register.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            last_q <= 2'd2;
        end else begin
            last_q <= last_d;
        end
    end

`endif

    // Word offered by the source that wins the current arbitration.
    always_comb begin
        case (pick_idx)
            2'd0:    pick_data = data0_i;
            2'd1:    pick_data = data1_i;
            default: pick_data = data2_i;
        endcase
    end

    // Arbitration points: every IDLE and TAIL cycle, and the last HOLD cycle.
    assign arb_en   = (state_q == ST_IDLE) ||
                      (state_q == ST_TAIL) ||
                      ((state_q == ST_HOLD) && (cnt_q == 4'd0));
    assign grant_go = arb_en && pick_valid;

    // Next-state and next-output logic; every output is registered, so the
    // values here describe the cycle after the coming edge.
    always_comb begin
        // NOTE: each signal written here gets a default first; any path
        // that skipped an assignment would otherwise infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = '0;
        valid_d  = 1'b0;
        gnt_d    = 3'b000;
        select_d = select_q;
        busy_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_go) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_LOAD;
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    if (grant_go) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_TAIL;
                        cnt_d   = TAIL_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_TAIL: begin
                if (grant_go) begin
                    state_d = ST_SEND;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Entering SEND: present the word, its select code and the grant.
        if (grant_go) begin
            valid_d         = 1'b1;
            data_d          = pick_data;
            select_d        = pick_idx;
            gnt_d[pick_idx] = 1'b1;
            cnt_d           = 4'd0;
        end

        // Entering IDLE releases the demux.
        if (state_d == ST_IDLE) begin
            select_d = SEL_NONE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and output registers; reset abandons any word in flight.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            select_q <= SEL_NONE;
            gnt_q    <= 3'b000;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            select_q <= select_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt0_o   = gnt_q[0];
    assign gnt1_o   = gnt_q[1];
    assign gnt2_o   = gnt_q[2];
    assign data_o   = data_q;
    assign valid_o  = valid_q;
    assign select_o = select_q;
    assign busy_o   = busy_q;

`ifndef SYNTHESIS
    // Output invariants the demux relies on.
    a_gnt_onehot : assert property (@(posedge clk_sys) disable iff (rst)
        $onehot0(gnt_q));
    a_gnt_with_valid : assert property (@(posedge clk_sys) disable iff (rst)
        (|gnt_q) == valid_q);
    a_no_back_to_back : assert property (@(posedge clk_sys) disable iff (rst)
        valid_q |=> !valid_q);
    a_busy_select : assert property (@(posedge clk_sys) disable iff (rst)
        busy_q == (select_q != SEL_NONE));
`endif

endmodule

// File: tb/tb_demux_arbiter.sv
// Self-checking bench for demux_arbiter. Source models hold each word until
// granted; expected words are queued in grant order when stimulus is applied
// and compared whenever the arbiter presents a word.

module tb_demux_arbiter;

    localparam int DW   = 32;
    localparam int SLOT = 4;

    typedef struct packed {
        logic [1:0]    sel;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk_sys = 1'b0;
    logic          rst;
    logic          req0_i, req1_i, req2_i;
    logic [DW-1:0] data0_i, data1_i, data2_i;
    logic          gnt0_o, gnt1_o, gnt2_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic [1:0]    select_o;
    logic          busy_o;

    always #5 clk_sys = ~clk_sys;

    demux_arbiter #(
        .MST_DWIDTH (DW),
        .SLOT_CYCLES(SLOT)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .req0_i  (req0_i),
        .req1_i  (req1_i),
        .req2_i  (req2_i),
        .data0_i (data0_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .gnt0_o  (gnt0_o),
        .gnt1_o  (gnt1_o),
        .gnt2_o  (gnt2_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .select_o(select_o),
        .busy_o  (busy_o)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_cycle  = 0;
    exp_t          sb_q [$];
    logic [DW-1:0] src0_q [$];
    logic [DW-1:0] src1_q [$];
    logic [DW-1:0] src2_q [$];
    int            valid_cycs [$];
    int            gnt_cnt [3];
    int            last_valid_cyc = -100;
    logic [1:0]    prev_sel = 2'b11;
    logic [2:0]    mon_gnt;
    exp_t          mon_exp;
    logic [DW-1:0] drop_word;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, n_cycle);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input int s, input int i);
        return 32'hC0DE_0000 | (32'(s) << 12) | 32'(i);
    endfunction

    function automatic exp_t mk_exp(input int s, input logic [DW-1:0] w);
        exp_t e;
        e.sel  = 2'(s);
        e.data = w;
        return e;
    endfunction

    // Compare DUT outputs against the scoreboard and the output invariants.
    task automatic monitor_step();
        if (!rst) begin
            mon_gnt = {gnt2_o, gnt1_o, gnt0_o};
            if (valid_o || (mon_gnt != 3'b000)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_word", 64'({valid_o, mon_gnt}), 64'(0));
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("word_valid",  64'(valid_o),  64'(1));
                    check("word_data",   64'(data_o),   64'(mon_exp.data));
                    check("word_select", 64'(select_o), 64'(mon_exp.sel));
                    check("word_gnt",    64'(mon_gnt),  64'(3'(3'b001 << mon_exp.sel)));
                    check("valid_gap",   64'((n_cycle - last_valid_cyc) >= 2), 64'(1));
                    last_valid_cyc = n_cycle;
                    valid_cycs.push_back(n_cycle);
                    for (int k = 0; k < 3; k++) begin
                        if (mon_gnt[k]) gnt_cnt[k]++;
                    end
                end
            end else begin
                check("idle_data_zero", 64'(data_o), 64'(0));
            end
            if (select_o != prev_sel) begin
                check("select_change_point",
                      64'(valid_o || ((select_o == 2'b11) && !busy_o)), 64'(1));
            end
            check("busy_vs_select", 64'(busy_o), 64'(select_o != 2'b11));
            prev_sel = select_o;
        end else begin
            prev_sel = 2'b11;
        end
    endtask

    // Source models: drop a word once its grant is seen, then offer the next.
    task automatic source_step(input bit consume);
        if (consume) begin
            if (gnt0_o && (src0_q.size() != 0)) drop_word = src0_q.pop_front();
            if (gnt1_o && (src1_q.size() != 0)) drop_word = src1_q.pop_front();
            if (gnt2_o && (src2_q.size() != 0)) drop_word = src2_q.pop_front();
        end
        req0_i  = (src0_q.size() != 0);
        req1_i  = (src1_q.size() != 0);
        req2_i  = (src2_q.size() != 0);
        data0_i = (src0_q.size() != 0) ? src0_q[0] : '0;
        data1_i = (src1_q.size() != 0) ? src1_q[0] : '0;
        data2_i = (src2_q.size() != 0) ? src2_q[0] : '0;
    endtask

    task automatic tick();
        @(negedge clk_sys);
        n_cycle++;
        monitor_step();
        source_step(1'b1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (((sb_q.size() != 0) || busy_o ||
                (src0_q.size() + src1_q.size() + src2_q.size() != 0)) && (n < budget)) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, 64'(n < budget), 64'(1));
    endtask

    initial begin
        logic [DW-1:0] w;

        rst = 1'b1;
        source_step(1'b0);

        // Reset values.
        repeat (2) tick();
        check("rst_valid",  64'(valid_o),  64'(0));
        check("rst_data",   64'(data_o),   64'(0));
        check("rst_select", 64'(select_o), 64'(2'b11));
        check("rst_busy",   64'(busy_o),   64'(0));
        check("rst_gnt",    64'({gnt2_o, gnt1_o, gnt0_o}), 64'(0));
        rst = 1'b0;

        // Single word from source 1.
        w = 32'h4443_4241;
        src1_q.push_back(w);
        sb_q.push_back(mk_exp(1, w));
        source_step(1'b0);
        tick();
        check("single_latency_valid", 64'(valid_o), 64'(1));
        check("single_gnt1",          64'(gnt1_o),  64'(1));
        for (int i = 0; i < 2 * SLOT - 1; i++) begin
            tick();
            check("single_select_held", 64'(select_o), 64'(2'b01));
            check("single_busy_held",   64'(busy_o),   64'(1));
            check("single_no_valid",    64'(valid_o),  64'(0));
        end
        tick();
        check("single_select_release", 64'(select_o), 64'(2'b11));
        check("single_busy_release",   64'(busy_o),   64'(0));

        // Request from source 2 arriving two cycles into TAIL.
        w = mk_word(0, 100);
        src0_q.push_back(w);
        sb_q.push_back(mk_exp(0, w));
        source_step(1'b0);
        for (int i = 0; i < SLOT + 3; i++) begin
            tick();
            check("tail_busy", 64'(busy_o), 64'(1));
        end
        check("tail_select_held", 64'(select_o), 64'(2'b00));
        w = mk_word(2, 101);
        src2_q.push_back(w);
        sb_q.push_back(mk_exp(2, w));
        source_step(1'b0);
        tick();
        check("tail_send_valid",  64'(valid_o),  64'(1));
        check("tail_send_select", 64'(select_o), 64'(2'b10));
        check("tail_send_busy",   64'(busy_o),   64'(1));
        wait_drain("tail", 100);

        // Contention: all three sources with 6 words each.
        valid_cycs.delete();
        for (int k = 0; k < 3; k++) gnt_cnt[k] = 0;
        for (int i = 0; i < 6; i++) begin
            src0_q.push_back(mk_word(0, i));
            src1_q.push_back(mk_word(1, i));
            src2_q.push_back(mk_word(2, i));
        end
`ifdef DEMUX_ARB_FIXED_PRIO_EN
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 6; i++) sb_q.push_back(mk_exp(s, mk_word(s, i)));
        end
`else
        for (int i = 0; i < 6; i++) begin
            for (int s = 0; s < 3; s++) sb_q.push_back(mk_exp(s, mk_word(s, i)));
        end
`endif
        source_step(1'b0);
        wait_drain("contention", 300);
        check("contention_words", 64'(valid_cycs.size()), 64'(18));
        for (int k = 0; k < 3; k++) begin
            check("contention_gnt_count", 64'(gnt_cnt[k]), 64'(6));
        end
        for (int i = 1; i < valid_cycs.size(); i++) begin
            check("contention_spacing", 64'(valid_cycs[i] - valid_cycs[i-1]), 64'(SLOT));
        end

        // Reset during HOLD with source 1 pending.
        w = mk_word(0, 200);
        src0_q.push_back(w);
        sb_q.push_back(mk_exp(0, w));
        source_step(1'b0);
        tick();
        check("rsthold_grant0", 64'(gnt0_o), 64'(1));
        src1_q.push_back(mk_word(1, 201));
        source_step(1'b0);
        @(posedge clk_sys);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid",  64'(valid_o),  64'(0));
        check("async_rst_data",   64'(data_o),   64'(0));
        check("async_rst_select", 64'(select_o), 64'(2'b11));
        check("async_rst_busy",   64'(busy_o),   64'(0));
        check("async_rst_gnt",    64'({gnt2_o, gnt1_o, gnt0_o}), 64'(0));
        tick();
        w = mk_word(0, 202);
        src0_q.push_back(w);
        sb_q.push_back(mk_exp(0, w));
        sb_q.push_back(mk_exp(1, mk_word(1, 201)));
        source_step(1'b0);
        rst = 1'b0;
        wait_drain("rsthold", 100);

        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
